// File: rtl/delay_sequencer_if.sv
// Request/completion handshake bundle between a delay requester and delay_sequencer.
// The master side issues tagged delay requests and consumes completions.
interface delay_sequencer_if #(
  parameter int DLY_W = 16,
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [DLY_W-1:0] req_delay;
  logic [TAG_W-1:0] req_tag;
  logic             cmp_valid;
  logic             cmp_ready;
  logic [TAG_W-1:0] cmp_tag;
  logic [1:0]       cmp_err;

  modport master (
    output req_valid, req_delay, req_tag, cmp_ready,
    input  req_ready, cmp_valid, cmp_tag, cmp_err
  );

  modport slave (
    input  req_valid, req_delay, req_tag, cmp_ready,
    output req_ready, cmp_valid, cmp_tag, cmp_err
  );
endinterface

// File: rtl/delay_sequencer.sv
// Queues tagged delay requests, loads the carry-save delay counter and checks its
// done flag against a shadow count, reporting one tagged status per request.
module delay_sequencer #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4,
  parameter int DLY_W = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  delay_sequencer_if.slave bus,
  output logic             ld,
  output logic [WIDTH-1:0] nb,
  input  logic             dn
);
  localparam int AW = $clog2(DEPTH);
  localparam int unsigned MIN_D = WIDTH;
  localparam int unsigned MAX_D = WIDTH - 1 + (1 << (WIDTH - 1));
  localparam logic [WIDTH-1:0] NB_BASE = WIDTH'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, REPORT} state_t;

  state_t           state;
  logic [DLY_W-1:0] mem_delay [DEPTH];
  logic [TAG_W-1:0] mem_tag   [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             alive;
  logic             full;
  logic             empty;
  logic             enq;
  logic             deq;
  logic [DLY_W-1:0] head_delay;
  logic [TAG_W-1:0] head_tag;
  logic             head_in_range;
  logic [DLY_W-1:0] d_lat;
  logic [DLY_W-1:0] d_last;
  logic [DLY_W-1:0] shadow;

  assign full          = (count == (AW+1)'(DEPTH));
  assign empty         = (count == '0);
  assign bus.req_ready = alive & ~full;
  assign enq           = bus.req_valid & bus.req_ready;
  assign deq           = (state == IDLE) & ~empty;
  assign head_delay    = mem_delay[rd_ptr];
  assign head_tag      = mem_tag[rd_ptr];
  assign head_in_range = (32'(head_delay) >= MIN_D) && (32'(head_delay) <= MAX_D);
  assign d_last        = d_lat - DLY_W'(1);

  always_ff @(posedge clk) begin
    if (enq) begin
      mem_delay[wr_ptr] <= bus.req_delay;
      mem_tag[wr_ptr]   <= bus.req_tag;
    end
  end

  // alive keeps req_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive  <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      alive <= 1'b1;
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      if (enq && !deq)      count <= count + 1'b1;
      else if (!enq && deq) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ld            <= 1'b0;
      nb            <= '0;
      d_lat         <= '0;
      shadow        <= '0;
      bus.cmp_valid <= 1'b0;
      bus.cmp_tag   <= '0;
      bus.cmp_err   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            d_lat       <= head_delay;
            bus.cmp_tag <= head_tag;
            if (head_in_range) begin
              // load value is (WIDTH-1-D) mod 2^WIDTH, so only the low delay bits matter
              nb    <= NB_BASE - head_delay[WIDTH-1:0];
              ld    <= 1'b1;
              state <= LOAD;
            end else begin
              bus.cmp_err   <= 2'd3;
              bus.cmp_valid <= 1'b1;
              state         <= REPORT;
            end
          end
        end
        LOAD: begin
          ld     <= 1'b0;
          shadow <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          shadow <= shadow + DLY_W'(1);
          if (dn && (shadow < d_last)) begin
            bus.cmp_err   <= 2'd1;
            bus.cmp_valid <= 1'b1;
            state         <= REPORT;
          end else if (shadow == d_last) begin
            bus.cmp_err   <= dn ? 2'd0 : 2'd2;
            bus.cmp_valid <= 1'b1;
            state         <= REPORT;
          end
        end
        REPORT: begin
          if (bus.cmp_ready) begin
            bus.cmp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_delay_sequencer.sv
// Bench for delay_sequencer: a behavioural delay counter drives dn, and each
// completion is compared against timing/status rules computed per request.
module tb_delay_sequencer;
  localparam int WIDTH = 5;
  localparam int DEPTH = 4;
  localparam int DLY_W = 16;
  localparam int TAG_W = 4;
  localparam int MIN_D = WIDTH;
  localparam int MAX_D = WIDTH - 1 + (1 << (WIDTH - 1));
  localparam int MOD   = 1 << WIDTH;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             ld;
  logic [WIDTH-1:0] nb;
  logic             dn    = 1'b0;

  delay_sequencer_if #(.DLY_W(DLY_W), .TAG_W(TAG_W)) bus ();

  delay_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DLY_W(DLY_W), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .ld    (ld),
    .nb    (nb),
    .dn    (dn)
  );

  always #5 clk = ~clk;

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int ld_cnt   = 0;
  int mode     = 0;   // 0: real counter, 1: dn forced high early, 2: dn stuck low
  int early_at = 3;
  int c0_seen  = -1000;
  int dcnt     = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ld === 1'b1) ld_cnt <= ld_cnt + 1;

  // Counter behaviour: after loading nb it raises done D cycles after the load cycle.
  function automatic int counter_delay(input logic [WIDTH-1:0] v);
    int d;
    d = (WIDTH - 1 - int'(v)) % MOD;
    if (d < 0) d += MOD;
    if (d < WIDTH) d += MOD;
    return d;
  endfunction

  always @(posedge clk) begin
    #1;
    if (ld === 1'b1) begin
      c0_seen = cyc;
      dcnt    = counter_delay(nb);
    end
    case (mode)
      0:       dn = (cyc >= c0_seen + dcnt);
      1:       dn = (cyc >= c0_seen + early_at);
      default: dn = 1'b0;
    endcase
  end

  function automatic int exp_nb(input int d);
    int v;
    v = (MOD - (d + 1 - WIDTH)) % MOD;
    if (v < 0) v += MOD;
    return v;
  endfunction

  function automatic int exp_err(input int d, input int m, input int e);
    if (d < MIN_D || d > MAX_D) return 3;
    if (m == 1 && e < d) return 1;
    if (m == 2) return 2;
    return 0;
  endfunction

  function automatic int exp_lat(input int d, input int m, input int e);
    if (m == 1 && e < d) return e + 1;
    return d + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input int tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (bus.req_ready === 1'b1) ok = 1'b1;
      else tick();
    end
    bus.req_valid = 1'b1;
    bus.req_delay = DLY_W'(d);
    bus.req_tag   = TAG_W'(tag);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_ld(output int c, output bit ok);
    ok = 1'b0;
    c  = -1;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (ld === 1'b1) begin ok = 1'b1; c = cyc; end
      else tick();
    end
  endtask

  task automatic wait_cmp(output int c, output bit ok);
    ok = 1'b0;
    c  = -1;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (bus.cmp_valid === 1'b1) begin ok = 1'b1; c = cyc; end
      else tick();
    end
  endtask

  task automatic accept();
    bus.cmp_ready = 1'b1;
    tick();
    bus.cmp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (ld !== 1'b0 || nb !== '0) begin
      errors++;
      $display("FAIL reset_ld: ld=%b nb=%0d, expected ld=0 nb=0", ld, nb);
    end
    checks++;
    if (bus.cmp_valid !== 1'b0 || bus.cmp_tag !== '0 || bus.cmp_err !== '0) begin
      errors++;
      $display("FAIL reset_cmp: valid=%b tag=%0d err=%0d, expected all 0", bus.cmp_valid, bus.cmp_tag, bus.cmp_err);
    end
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: req_ready=%b, expected 0", bus.req_ready);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release: req_ready=%b, expected 1", bus.req_ready);
    end
  endtask

  task automatic test_single_requests();
    int dq[$], tq[$], mq[$], eq[$];
    dq = '{10, 5, 20, 4, 21, 10, 10};
    tq = '{ 3, 1,  2, 4,  5,  6,  7};
    mq = '{ 0, 0,  0, 0,  0,  1,  2};
    eq = '{ 0, 0,  0, 0,  0,  3,  0};
    for (int i = 0; i < 12; i++) begin
      int d;
      d = int'($urandom_range(2, 24));
      dq.push_back(d);
      tq.push_back(int'($urandom_range(0, 15)));
      mq.push_back(int'($urandom_range(0, 2)));
      eq.push_back(int'($urandom_range(1, d - 1)));
    end
    for (int i = 0; i < dq.size(); i++) begin
      int d, tg, m, e, ee, c0, cc, l0;
      bit ok;
      d = dq[i]; tg = tq[i]; m = mq[i]; e = eq[i];
      mode = m; early_at = e;
      ee = exp_err(d, m, e);
      l0 = ld_cnt;
      push(d, tg, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL push_timeout d=%0d: req_ready never 1", d); end
      if (ee == 3) begin
        tick();
        checks++;
        if (bus.cmp_valid !== 1'b1 || bus.cmp_err !== 2'd3 || bus.cmp_tag !== TAG_W'(tg)) begin
          errors++;
          $display("FAIL range_cmp d=%0d: valid=%b err=%0d tag=%0d, expected valid=1 err=3 tag=%0d",
                   d, bus.cmp_valid, bus.cmp_err, bus.cmp_tag, tg);
        end
        checks++;
        if (ld_cnt != l0) begin
          errors++;
          $display("FAIL range_no_ld d=%0d: ld pulses=%0d, expected 0", d, ld_cnt - l0);
        end
      end else begin
        wait_ld(c0, ok);
        checks++;
        if (!ok || nb !== WIDTH'(exp_nb(d))) begin
          errors++;
          $display("FAIL load_nb d=%0d: ld_seen=%b nb=%0d, expected ld nb=%0d", d, ok, nb, exp_nb(d));
        end
        tick();
        checks++;
        if (ld !== 1'b0) begin
          errors++;
          $display("FAIL ld_pulse d=%0d: ld=%b in cycle after load, expected 0", d, ld);
        end
        wait_cmp(cc, ok);
        checks++;
        if (!ok || (cc - c0) != exp_lat(d, m, e)) begin
          errors++;
          $display("FAIL cmp_latency d=%0d mode=%0d e=%0d: got %0d (seen=%b), expected %0d",
                   d, m, e, cc - c0, ok, exp_lat(d, m, e));
        end
        checks++;
        if (bus.cmp_err !== 2'(ee) || bus.cmp_tag !== TAG_W'(tg)) begin
          errors++;
          $display("FAIL cmp_status d=%0d mode=%0d: err=%0d tag=%0d, expected err=%0d tag=%0d",
                   d, m, bus.cmp_err, bus.cmp_tag, ee, tg);
        end
        checks++;
        if (ld_cnt != l0 + 1) begin
          errors++;
          $display("FAIL ld_count d=%0d: ld pulses=%0d, expected 1", d, ld_cnt - l0);
        end
      end
      repeat ($urandom_range(0, 2)) tick();
      accept();
      checks++;
      if (bus.cmp_valid !== 1'b0) begin
        errors++;
        $display("FAIL cmp_drop d=%0d: cmp_valid=%b after handshake, expected 0", d, bus.cmp_valid);
      end
    end
  endtask

  task automatic test_fifo_full();
    int dl[5];
    int c0, cc;
    bit ok;
    mode = 0;
    foreach (dl[i]) dl[i] = int'($urandom_range(MIN_D, MAX_D));
    push(20, 1, ok);
    wait_ld(c0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL full_first_ld: no ld seen, expected one"); end
    tick();
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (bus.req_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill_ready n=%0d: req_ready=%b, expected 1", n, bus.req_ready);
      end
      bus.req_valid = 1'b1;
      bus.req_delay = DLY_W'(dl[n]);
      bus.req_tag   = TAG_W'(n + 2);
      tick();
    end
    bus.req_delay = DLY_W'(dl[4]);
    bus.req_tag   = TAG_W'(6);
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: req_ready=%b after 4 accepted, expected 0", bus.req_ready);
    end
    wait_cmp(cc, ok);
    checks++;
    if (!ok || bus.cmp_tag !== TAG_W'(1) || bus.cmp_err !== 2'd0) begin
      errors++;
      $display("FAIL full_first_cmp: seen=%b tag=%0d err=%0d, expected tag=1 err=0", ok, bus.cmp_tag, bus.cmp_err);
    end
    accept();
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL no_passthrough: req_ready=%b during dequeue cycle, expected 0", bus.req_ready);
    end
    tick();
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_return: req_ready=%b after dequeue, expected 1", bus.req_ready);
    end
    tick();
    bus.req_valid = 1'b0;
    for (int n = 0; n < 5; n++) begin
      wait_cmp(cc, ok);
      checks++;
      if (!ok || bus.cmp_tag !== TAG_W'(n + 2) || bus.cmp_err !== 2'd0) begin
        errors++;
        $display("FAIL order n=%0d: seen=%b tag=%0d err=%0d, expected tag=%0d err=0",
                 n, ok, bus.cmp_tag, bus.cmp_err, n + 2);
      end
      accept();
    end
  endtask

  task automatic test_backpressure();
    int c, cc, h, l0;
    bit ok, ok2, stable;
    mode = 0;
    push(7, 9, ok);
    push(8, 10, ok2);
    wait_cmp(cc, ok);
    checks++;
    if (!ok || bus.cmp_tag !== TAG_W'(9) || bus.cmp_err !== 2'd0) begin
      errors++;
      $display("FAIL bp_first: seen=%b tag=%0d err=%0d, expected tag=9 err=0", ok, bus.cmp_tag, bus.cmp_err);
    end
    l0 = ld_cnt;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.cmp_valid !== 1'b1 || bus.cmp_tag !== TAG_W'(9) || bus.cmp_err !== 2'd0) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL bp_stable: valid=%b tag=%0d err=%0d, expected held valid=1 tag=9 err=0",
               bus.cmp_valid, bus.cmp_tag, bus.cmp_err);
    end
    checks++;
    if (ld_cnt != l0) begin
      errors++;
      $display("FAIL bp_no_ld: ld pulses=%0d while stalled, expected 0", ld_cnt - l0);
    end
    h = cyc;
    accept();
    wait_ld(c, ok);
    checks++;
    if (!ok || (c - h) != 2) begin
      errors++;
      $display("FAIL bp_next_ld: ld %0d cycles after handshake (seen=%b), expected 2", c - h, ok);
    end
    wait_cmp(cc, ok);
    checks++;
    if (!ok || bus.cmp_tag !== TAG_W'(10) || bus.cmp_err !== 2'd0) begin
      errors++;
      $display("FAIL bp_second: seen=%b tag=%0d err=%0d, expected tag=10 err=0", ok, bus.cmp_tag, bus.cmp_err);
    end
    accept();
  endtask

  task automatic test_reset_mid_wait();
    int c0, cc, l0;
    bit ok;
    mode = 0;
    push(10, 1, ok);
    wait_ld(c0, ok);
    rst_n = 1'b0;
    #1;
    checks++;
    if (ld !== 1'b0 || nb !== '0) begin
      errors++;
      $display("FAIL async_ld: ld=%b nb=%0d right after reset, expected 0 0", ld, nb);
    end
    tick();
    rst_n = 1'b1;
    tick();
    push(10, 1, ok);
    wait_ld(c0, ok);
    push(12, 2, ok);
    push(13, 3, ok);
    for (int i = 0; i < 20 && cyc < c0 + 4; i++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (ld !== 1'b0 || bus.cmp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: ld=%b cmp_valid=%b req_ready=%b, expected 0 0 0",
               ld, bus.cmp_valid, bus.req_ready);
    end
    tick();
    rst_n = 1'b1;
    l0 = ld_cnt;
    repeat (6) tick();
    checks++;
    if (ld_cnt != l0 || bus.cmp_valid !== 1'b0) begin
      errors++;
      $display("FAIL flushed: ld pulses=%0d cmp_valid=%b after reset, expected 0 0", ld_cnt - l0, bus.cmp_valid);
    end
    push(6, 5, ok);
    wait_ld(c0, ok);
    checks++;
    if (!ok || nb !== WIDTH'(exp_nb(6))) begin
      errors++;
      $display("FAIL post_reset_nb: seen=%b nb=%0d, expected %0d", ok, nb, exp_nb(6));
    end
    wait_cmp(cc, ok);
    checks++;
    if (!ok || (cc - c0) != 7 || bus.cmp_tag !== TAG_W'(5) || bus.cmp_err !== 2'd0) begin
      errors++;
      $display("FAIL post_reset_cmp: latency=%0d tag=%0d err=%0d, expected 7 5 0", cc - c0, bus.cmp_tag, bus.cmp_err);
    end
    accept();
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_delay = '0;
    bus.req_tag   = '0;
    bus.cmp_ready = 1'b0;
    test_reset();
    test_single_requests();
    test_fifo_full();
    test_backpressure();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
